// File: rtl/bsg_gateway_link_tester.sv
// bsg_gateway_link_tester: drives a counting pattern into the gateway link and checks the loopback.
// Define BSG_GATEWAY_LINK_TESTER_BACKPRESSURE_EN to throttle receive acceptance with a 16-bit LFSR.
module bsg_gateway_link_tester #(
    parameter int width_p     = 32,
    parameter int cnt_width_p = 16,
    parameter int timeout_p   = 1024
) (
    input  logic                   core_clk_i,
    input  logic                   core_reset_i,
    input  logic                   start_i,
    input  logic [cnt_width_p-1:0] num_packets_i,
    input  logic [width_p-1:0]     seed_i,
    output logic                   link_v_o,
    output logic [width_p-1:0]     link_data_o,
    input  logic                   link_ready_and_i,
    input  logic                   link_v_i,
    input  logic [width_p-1:0]     link_data_i,
    output logic                   link_yumi_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   timeout_o,
    output logic [cnt_width_p-1:0] sent_count_o,
    output logic [cnt_width_p-1:0] recv_count_o,
    output logic [cnt_width_p-1:0] err_count_o
);

    localparam int tmo_width_lp = $clog2(timeout_p + 1);
    localparam logic [tmo_width_lp-1:0] tmo_last_lp = tmo_width_lp'(timeout_p - 1);
    localparam logic [tmo_width_lp-1:0] tmo_one_lp  = tmo_width_lp'(1);
    localparam logic [cnt_width_p-1:0]  cnt_one_lp  = cnt_width_p'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [cnt_width_p-1:0]   num_q, num_d;
    logic [width_p-1:0]       seed_q, seed_d;
    logic [cnt_width_p-1:0]   sent_q, sent_d;
    logic [cnt_width_p-1:0]   recv_q, recv_d;
    logic [cnt_width_p-1:0]   err_q, err_d;
    logic [tmo_width_lp-1:0]  tmo_q, tmo_d;
    logic                     timeout_q, timeout_d;

    logic                     active;
    logic                     recv_open;
    logic                     recv_gate;
    logic                     send_hs;
    logic                     recv_hs;
    logic [width_p-1:0]       expected_data;

    assign active    = (state_q == SEND) || (state_q == DRAIN);
    assign recv_open = active && (recv_q < num_q) && !core_reset_i;

`ifdef BSG_GATEWAY_LINK_TESTER_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            lfsr_q <= 16'h0001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign recv_gate = recv_open && lfsr_q[0];
`else
    assign recv_gate = recv_open;
`endif

    assign link_v_o      = (state_q == SEND) && (sent_q < num_q) && !core_reset_i;
    assign link_data_o   = seed_q + width_p'(sent_q);
    assign link_yumi_o   = link_v_i && recv_gate;
    assign send_hs       = link_v_o && link_ready_and_i;
    assign recv_hs       = link_yumi_o;
    assign expected_data = seed_q + width_p'(recv_q);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        seed_d    = seed_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = SEND;
                    num_d     = num_packets_i;
                    seed_d    = seed_i;
                    sent_d    = '0;
                    recv_d    = '0;
                    err_d     = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            SEND, DRAIN: begin
                if (send_hs) begin
                    sent_d = sent_q + cnt_one_lp;
                end
                if (recv_hs) begin
                    recv_d = recv_q + cnt_one_lp;
                    if ((link_data_i != expected_data) && (err_q != '1)) begin
                        err_d = err_q + cnt_one_lp;
                    end
                end
                if (send_hs || recv_hs) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + tmo_one_lp;
                end
                // A stuck link wins over normal progress only on an idle cycle
                if (!send_hs && !recv_hs && (tmo_q == tmo_last_lp)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else if ((state_q == SEND) && (sent_d == num_q)) begin
                    state_d = DRAIN;
                end else if ((state_q == DRAIN) && (recv_d == num_q)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            state_q   <= IDLE;
            num_q     <= '0;
            seed_q    <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            err_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            seed_q    <= seed_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign done_o       = (state_q == DONE) && !core_reset_i;
    assign pass_o       = done_o && !timeout_q && (err_q == '0) && (recv_q == num_q);
    assign timeout_o    = timeout_q;
    assign sent_count_o = sent_q;
    assign recv_count_o = recv_q;
    assign err_count_o  = err_q;

endmodule

// File: doc/bsg_gateway_link_tester.md
BSG_GATEWAY_LINK_TESTER -- requirements
Module: bsg_gateway_link_tester

Interface
REQ-001 SHALL have parameter width_p, default 32: link packet width, matching the core-side width of the gateway DDR link.
REQ-002 SHALL have parameter cnt_width_p, default 16: width of the packet-count, sequence and error counters.
REQ-003 SHALL have parameter timeout_p, default 1024: number of idle cycles allowed in SEND or DRAIN before a timeout.
REQ-004 SHALL have port core_clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port core_reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1 bit: start pulse, sampled in IDLE or DONE.
REQ-007 SHALL have port num_packets_i, input, cnt_width_p bits: number of packets per run, latched at start.
REQ-008 SHALL have port seed_i, input, width_p bits: first data value, latched at start.
REQ-009 SHALL have ports link_v_o (output, 1), link_data_o (output, width_p) and link_ready_and_i (input, 1): packets to the link uplink core side.
REQ-010 SHALL have ports link_v_i (input, 1), link_data_i (input, width_p) and link_yumi_o (output, 1): packets from the link downlink core side.
REQ-011 SHALL have ports done_o, pass_o and timeout_o (outputs, 1 bit each), and sent_count_o, recv_count_o and err_count_o (outputs, cnt_width_p each).

Function
REQ-012 SHALL implement the states IDLE, SEND, DRAIN and DONE.
REQ-013 In IDLE or DONE, start_i=1 SHALL move the block to SEND on the next edge:
- latch num_packets_i and seed_i;
- clear sent, recv, err and the timeout counter;
- clear timeout_o.
REQ-014 In SEND:
- link_v_o = (sent < num);
- link_data_o = seed + sent, modulo 2^width_p;
- sent increments on link_v_o & link_ready_and_i.
REQ-015 Once link_v_o is asserted, it and link_data_o SHALL stay stable until the handshake occurs.
REQ-016 SEND SHALL go to DRAIN on the edge where sent reaches num. When num=0, SEND SHALL go to DRAIN after one cycle without asserting link_v_o.
REQ-017 In SEND and DRAIN, link_yumi_o SHALL equal link_v_i & (recv < num), subject to REQ-029. link_yumi_o SHALL be 0 in IDLE and DONE.
REQ-018 Each received packet SHALL be compared against seed + recv.
- Mismatch: err increments, saturating at all-ones.
- recv increments on every accepted packet, whether it matched or not.
REQ-019 DRAIN SHALL go to DONE when recv == num.
REQ-020 The timeout counter SHALL clear on any send or receive handshake and increment every other cycle in SEND or DRAIN. When it reaches timeout_p-1, the block SHALL go to DONE with timeout_o=1.
REQ-021 done_o SHALL be 1 exactly while in DONE.
REQ-022 pass_o SHALL equal done_o & ~timeout_o & (err==0) & (recv==num).
REQ-023 sent_count_o, recv_count_o and err_count_o SHALL expose the live counters and hold their values in DONE.
REQ-024 start_i SHALL be ignored in SEND and DRAIN.
REQ-025 A send handshake and a receive handshake in the same cycle SHALL both be counted.

Reset
REQ-026 core_reset_i=1 SHALL, on the next edge, force the following, from any state including mid-run:
- state to IDLE;
- all counters, latched num and seed, and timeout_o to 0.
REQ-027 During and after reset, link_v_o, link_yumi_o, done_o and pass_o SHALL be 0. A partially sent run SHALL be abandoned with no further handshakes.

Configuration
REQ-028 The macro BSG_GATEWAY_LINK_TESTER_BACKPRESSURE_EN SHALL select whether receive-side backpressure is compiled in.
REQ-029 With BSG_GATEWAY_LINK_TESTER_BACKPRESSURE_EN defined:
- a 16-bit maximal-length LFSR, seeded to 16'h0001 at reset, advances every cycle;
- link_yumi_o is additionally gated by LFSR bit 0;
- timeout counting is unchanged.
REQ-030 Without the macro, REQ-017 SHALL apply unmodified and no LFSR SHALL be instantiated.

Verification
REQ-031 Loopback with ready_and always 1, num=8, seed=32'h100: send data 0x100..0x107; done_o and pass_o =1, err=0, recv=8.
REQ-032 Loopback with num=4 and the third returned word corrupted by XOR 1: err=1, recv=4, pass_o=0, timeout_o=0.
REQ-033 link_ready_and_i held 0 for 1024 cycles after start, timeout_p=1024: DONE with timeout_o=1, sent=0, pass_o=0.
REQ-034 num=0 started: DONE within 3 cycles, pass_o=1, and link_v_o never asserted.
REQ-035 Reset asserted after 3 of 8 packets are sent: next cycle state is IDLE, all outputs 0; a subsequent start with num=2 passes.
REQ-036 With BSG_GATEWAY_LINK_TESTER_BACKPRESSURE_EN defined, num=64 loopback: link_yumi_o is 0 on some cycles where link_v_i=1, and the run still ends with pass_o=1.
